// File: rtl/gru_ctrl_pkg.sv
// Shared types and constants for the GRU cell sequencer.
package gru_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_OP,
    S_RUN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [31:0] Q_ONE  = 32'h0100_0000;
  localparam logic [31:0] Q_ZERO = 32'h0000_0000;

  // Two CORDIC passes (sigmoid then tanh) plus the cell's surrounding mul/add stages.
  function automatic int gru_lat_default(input int cordic_lat);
    return 2 * cordic_lat + 6;
  endfunction

endpackage

// File: rtl/hidden_bank.sv
// Double-banked hidden-state store: writes go to cur, reads come from prev.
module hidden_bank #(
  parameter int DATA_WIDTH  = 32,
  parameter int HIDDEN_SIZE = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           toggle,
  input  logic                           wr_en,
  input  logic                           wr_prev,
  input  logic [$clog2(HIDDEN_SIZE)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [$clog2(HIDDEN_SIZE)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  input  logic [$clog2(HIDDEN_SIZE)-1:0] ar_addr,
  output logic [DATA_WIDTH-1:0]          ar_data
);

  logic                  sel;
  logic [DATA_WIDTH-1:0] mem [2][HIDDEN_SIZE];

  always_ff @(posedge clk) begin
    if (rst) sel <= 1'b0;
    else if (toggle) sel <= ~sel;
  end

  // sel names the cur bank; contents are not reset, CLEAR zeroes prev instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_prev ? ~sel : sel][wr_addr] <= wr_data;
    rd_data <= mem[~sel][rd_addr];
  end

  assign ar_data = mem[~sel][ar_addr];

endmodule

// File: rtl/gru_seq_ctrl.sv
// Sequencer for one GRU cell: feeds gate operands, holds them for the cell's
// settling window, captures the new hidden value into the bank and result stream.
module gru_seq_ctrl
  import gru_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int HIDDEN_SIZE = 64,
  parameter int SEQ_W       = 8,
  parameter int CORDIC_LAT  = 16,
  parameter int GRU_LAT     = gru_lat_default(CORDIC_LAT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [SEQ_W-1:0]               seq_len,
  output logic                           busy,
  output logic                           done,
  input  logic                           op_valid,
  output logic                           op_ready,
  input  logic [DATA_WIDTH-1:0]          op_ir,
  input  logic [DATA_WIDTH-1:0]          op_iz,
  input  logic [DATA_WIDTH-1:0]          op_in,
  input  logic [DATA_WIDTH-1:0]          op_hr,
  input  logic [DATA_WIDTH-1:0]          op_hz,
  input  logic [DATA_WIDTH-1:0]          op_hn,
  output logic [DATA_WIDTH-1:0]          gru_ir,
  output logic [DATA_WIDTH-1:0]          gru_iz,
  output logic [DATA_WIDTH-1:0]          gru_in,
  output logic [DATA_WIDTH-1:0]          gru_hr,
  output logic [DATA_WIDTH-1:0]          gru_hz,
  output logic [DATA_WIDTH-1:0]          gru_hn,
  output logic [DATA_WIDTH-1:0]          gru_hidden_in,
  input  logic [DATA_WIDTH-1:0]          gru_hidden_out,
  output logic                           h_out_valid,
  input  logic                           h_out_ready,
  output logic [DATA_WIDTH-1:0]          h_out_data,
  output logic [$clog2(HIDDEN_SIZE)-1:0] h_out_idx,
  output logic                           h_out_last,
  input  logic [$clog2(HIDDEN_SIZE)-1:0] h_rd_addr,
  output logic [DATA_WIDTH-1:0]          h_rd_data
);

  localparam int IDX_W = $clog2(HIDDEN_SIZE);
  localparam int CNT_W = $clog2(GRU_LAT + 1);
  localparam logic [IDX_W-1:0] ELEM_MAX = IDX_W'(HIDDEN_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GRU_LAT);

  state_t                       state, state_nxt;
  logic [IDX_W-1:0]             elem, clr_idx;
  logic [SEQ_W-1:0]             step, step_inc, seq_len_q;
  logic [CNT_W-1:0]             cnt;
  logic signed [DATA_WIDTH-1:0] ir_p0, iz_p0, in_p0, hr_p0, hz_p0, hn_p0, hin_p0;
  logic signed [DATA_WIDTH-1:0] res_p1;
  logic [DATA_WIDTH-1:0]        bank_hin;
  logic                         vld_p1, op_fire, out_fire, cap, elem_wrap, clearing;

  assign step_inc  = step + 1'b1;
  assign elem_wrap = (elem == ELEM_MAX);
  assign clearing  = (state == S_CLEAR);
  assign op_fire   = (state == S_WAIT_OP) && op_valid;
  assign cap       = (state == S_RUN) && (cnt == CNT_MAX);
  assign out_fire  = vld_p1 && h_out_ready;

  always_comb begin
    state_nxt  = state;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    op_ready   = (state == S_WAIT_OP);
    vld_p1     = (state == S_WRITE);
    h_out_last = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nxt = (seq_len == '0) ? S_DONE : S_CLEAR;
      S_CLEAR:   if (clr_idx == ELEM_MAX) state_nxt = S_WAIT_OP;
      S_WAIT_OP: if (op_valid) state_nxt = S_RUN;
      S_RUN:     if (cnt == CNT_MAX) state_nxt = S_WRITE;
      S_WRITE: begin
        h_out_last = elem_wrap && (step_inc == seq_len_q);
        if (h_out_ready) state_nxt = (elem_wrap && step_inc == seq_len_q) ? S_DONE : S_WAIT_OP;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      elem      <= '0;
      clr_idx   <= '0;
      step      <= '0;
      seq_len_q <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        seq_len_q <= seq_len;
        clr_idx   <= '0;
        elem      <= '0;
        step      <= '0;
      end
      if (clearing) clr_idx <= clr_idx + 1'b1;
      if (op_fire) cnt <= '0;
      else if (state == S_RUN) cnt <= cnt + 1'b1;
      if (out_fire) begin
        elem <= elem_wrap ? '0 : elem + 1'b1;
        if (elem_wrap) step <= step_inc;
      end
    end
  end

  // p0: operand holding registers, stable for the whole RUN window
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_p0  <= '0;
      iz_p0  <= '0;
      in_p0  <= '0;
      hr_p0  <= '0;
      hz_p0  <= '0;
      hn_p0  <= '0;
      hin_p0 <= '0;
    end else if (op_fire) begin
      ir_p0  <= op_ir;
      iz_p0  <= op_iz;
      in_p0  <= op_in;
      hr_p0  <= op_hr;
      hz_p0  <= op_hz;
      hn_p0  <= op_hn;
      hin_p0 <= bank_hin;
    end
  end

  // p1: captured cell result, presented on the result stream
  always_ff @(posedge clk) begin
    if (rst) res_p1 <= '0;
    else if (cap) res_p1 <= gru_hidden_out;
  end

  hidden_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .HIDDEN_SIZE(HIDDEN_SIZE)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .toggle (out_fire && elem_wrap),
    .wr_en  (cap || clearing),
    .wr_prev(clearing),
    .wr_addr(clearing ? clr_idx : elem),
    .wr_data(clearing ? Q_ZERO[DATA_WIDTH-1:0] : gru_hidden_out),
    .rd_addr(h_rd_addr),
    .rd_data(h_rd_data),
    .ar_addr(elem),
    .ar_data(bank_hin)
  );

  assign gru_ir        = ir_p0;
  assign gru_iz        = iz_p0;
  assign gru_in        = in_p0;
  assign gru_hr        = hr_p0;
  assign gru_hz        = hz_p0;
  assign gru_hn        = hn_p0;
  assign gru_hidden_in = hin_p0;
  assign h_out_valid   = vld_p1;
  assign h_out_data    = res_p1;
  assign h_out_idx     = elem;

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Directed bench for gru_seq_ctrl with HIDDEN_SIZE=4 and a short CORDIC latency.
module tb_gru_seq_ctrl;

  localparam int DW   = 32;
  localparam int HS   = 4;
  localparam int SW   = 8;
  localparam int CL   = 2;
  localparam int GLAT = 10;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [SW-1:0] seq_len = '0;
  logic          busy, done, op_ready, h_out_valid, h_out_last;
  logic          op_valid = 1'b0, h_out_ready = 1'b0;
  logic [DW-1:0] op_ir = '0, op_iz = '0, op_in = '0, op_hr = '0, op_hz = '0, op_hn = '0;
  logic [DW-1:0] gru_ir, gru_iz, gru_in, gru_hr, gru_hz, gru_hn, gru_hidden_in, gru_hidden_out;
  logic [DW-1:0] h_out_data, h_rd_data;
  logic [1:0]    h_out_idx;
  logic [1:0]    h_rd_addr = '0;
  logic [31:0]   cyc = '0;
  int            mode = 0;
  int            checks = 0, errors = 0;

  typedef struct {
    logic [31:0] ir, iz, in_, hr, hz, hn, hin, out;
  } vec_t;

  vec_t tbl[8];
  vec_t cv;

  gru_seq_ctrl #(
    .DATA_WIDTH(DW), .HIDDEN_SIZE(HS), .SEQ_W(SW), .CORDIC_LAT(CL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .busy(busy), .done(done),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_ir(op_ir), .op_iz(op_iz), .op_in(op_in), .op_hr(op_hr), .op_hz(op_hz), .op_hn(op_hn),
    .gru_ir(gru_ir), .gru_iz(gru_iz), .gru_in(gru_in), .gru_hr(gru_hr), .gru_hz(gru_hz),
    .gru_hn(gru_hn), .gru_hidden_in(gru_hidden_in), .gru_hidden_out(gru_hidden_out),
    .h_out_valid(h_out_valid), .h_out_ready(h_out_ready), .h_out_data(h_out_data),
    .h_out_idx(h_out_idx), .h_out_last(h_out_last),
    .h_rd_addr(h_rd_addr), .h_rd_data(h_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cell model: constant, pass-through sum, or cycle stamp to pin the capture edge.
  always_comb begin
    case (mode)
      0:       gru_hidden_out = 32'h0080_0000;
      1:       gru_hidden_out = gru_ir + gru_hidden_in;
      default: gru_hidden_out = cyc;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_seq(input logic [SW-1:0] n);
    start = 1'b1;
    seq_len = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_elem(input vec_t v, input bit use_cyc, input logic [1:0] xidx,
                         input bit xlast, input int stall, input int hold);
    int n;
    logic [31:0]  a, xout;
    logic [223:0] held;
    logic [35:0]  osnap;
    n = 0;
    while (op_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("op_ready_up", op_ready, 1);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_no_run", {op_ready, busy}, 2'b11);
    end
    op_ir = v.ir; op_iz = v.iz; op_in = v.in_; op_hr = v.hr; op_hz = v.hz; op_hn = v.hn;
    op_valid = 1'b1;
    a = cyc;
    @(negedge clk);
    op_valid = 1'b0;
    op_ir = ~v.ir; op_iz = ~v.iz; op_in = ~v.in_; op_hr = ~v.hr; op_hz = ~v.hz; op_hn = ~v.hn;
    held = {v.ir, v.iz, v.in_, v.hr, v.hz, v.hn, v.hin};
    for (int k = 0; k <= GLAT; k++) begin
      chk("gru_ports_run", {gru_ir, gru_iz, gru_in, gru_hr, gru_hz, gru_hn, gru_hidden_in}, held);
      chk("run_quiet", {h_out_valid, op_ready, done}, 3'b000);
      @(negedge clk);
    end
    xout = use_cyc ? a + 1 + GLAT : v.out;
    chk("h_out_valid", h_out_valid, 1);
    chk("h_out_data", h_out_data, xout);
    chk("h_out_idx", h_out_idx, xidx);
    chk("h_out_last", h_out_last, xlast);
    osnap = {h_out_valid, h_out_last, h_out_idx, h_out_data};
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_stable", {h_out_valid, h_out_last, h_out_idx, h_out_data}, osnap);
      chk("hold_no_op_ready", op_ready, 0);
    end
    h_out_ready = 1'b1;
    @(negedge clk);
    h_out_ready = 1'b0;
    chk("done_after_beat", done, xlast);
  endtask

  initial begin
    logic seen;
    int n;
    // step 0 (hidden_in cleared) then step 1 (hidden_in = step-0 result), out = ir + hidden_in
    tbl[0] = '{32'h0010_0000, 32'hA000_0001, 32'hB000_0001, 32'hC000_0001, 32'hD000_0001, 32'hE000_0001, 32'h0000_0000, 32'h0010_0000};
    tbl[1] = '{32'h0020_0000, 32'hA000_0002, 32'hB000_0002, 32'hC000_0002, 32'hD000_0002, 32'hE000_0002, 32'h0000_0000, 32'h0020_0000};
    tbl[2] = '{32'h0030_0000, 32'hA000_0003, 32'hB000_0003, 32'hC000_0003, 32'hD000_0003, 32'hE000_0003, 32'h0000_0000, 32'h0030_0000};
    tbl[3] = '{32'h0040_0000, 32'hA000_0004, 32'hB000_0004, 32'hC000_0004, 32'hD000_0004, 32'hE000_0004, 32'h0000_0000, 32'h0040_0000};
    tbl[4] = '{32'h0001_0000, 32'hA100_0001, 32'hB100_0001, 32'hC100_0001, 32'hD100_0001, 32'hE100_0001, 32'h0010_0000, 32'h0011_0000};
    tbl[5] = '{32'h0002_0000, 32'hA100_0002, 32'hB100_0002, 32'hC100_0002, 32'hD100_0002, 32'hE100_0002, 32'h0020_0000, 32'h0022_0000};
    tbl[6] = '{32'h0003_0000, 32'hA100_0003, 32'hB100_0003, 32'hC100_0003, 32'hD100_0003, 32'hE100_0003, 32'h0030_0000, 32'h0033_0000};
    tbl[7] = '{32'h0004_0000, 32'hA100_0004, 32'hB100_0004, 32'hC100_0004, 32'hD100_0004, 32'hE100_0004, 32'h0040_0000, 32'h0044_0000};

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, op_ready, h_out_valid, h_out_last}, 5'b00000);
    chk("rst_gru", {gru_ir, gru_iz, gru_in, gru_hr, gru_hz, gru_hn, gru_hidden_in}, '0);
    chk("rst_h_out", {h_out_data, h_out_idx}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // zero-length sequence
    start_seq(8'd0);
    chk("zl_busy", busy, 1);
    chk("zl_done", {done, h_out_valid}, 2'b10);
    @(negedge clk);
    chk("zl_idle", {busy, done}, 2'b00);

    // seq_len=1, constant model, with stall, backpressure and start-while-busy
    mode = 0;
    start_seq(8'd1);
    for (int i = 0; i < HS; i++) begin
      cv = '{32'h0100_0000 + i, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000,
             32'h0500_0000, 32'h0600_0000, 32'h0, 32'h0080_0000};
      do_elem(cv, 1'b0, 2'(i), i == HS - 1, (i == 1) ? 5 : 0, (i == 2) ? 10 : 0);
      if (i == 0) start_seq(8'd3);
    end
    @(negedge clk);
    chk("a_end_idle", {busy, done}, 2'b00);

    // seq_len=2, sum model: table-driven
    mode = 1;
    start_seq(8'd2);
    for (int i = 0; i < 8; i++) do_elem(tbl[i], 1'b0, 2'(i), i == 7, 0, 0);
    @(negedge clk);
    chk("b_end_idle", {busy, done}, 2'b00);
    for (int i = 0; i < HS; i++) begin
      h_rd_addr = 2'(i);
      @(negedge clk);
      chk("h_rd_data", h_rd_data, tbl[4 + i].out);
    end

    // seq_len=1, cycle-stamp model: capture edge
    mode = 2;
    start_seq(8'd1);
    for (int i = 0; i < HS; i++) begin
      cv = '{32'h7000_0000 + i, 32'h7100_0000, 32'h7200_0000, 32'h7300_0000,
             32'h7400_0000, 32'h7500_0000, 32'h0, 32'h0};
      do_elem(cv, 1'b1, 2'(i), i == HS - 1, 0, 0);
    end

    // reset in the middle of RUN
    mode = 0;
    @(negedge clk);
    start_seq(8'd3);
    n = 0;
    while (op_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("d_op_ready", op_ready, 1);
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("d_in_run", {busy, op_ready, h_out_valid}, 3'b100);
    rst = 1'b1;
    @(negedge clk);
    chk("d_rst_ctrl", {busy, h_out_valid, done, op_ready}, 4'b0000);
    chk("d_rst_gru", gru_ir, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      seen = seen | done | h_out_valid | busy;
    end
    chk("d_post_rst_quiet", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
